// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : IF stage - PC, I-cache req/ready fetch, stall buffer, branch flush.
// Rev    : 1.0
// ============================================================================
module instr_fetch #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 8'h00,
  parameter logic [15:0]         NOP_IR   = 16'h0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                state,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_addr,
  output logic                ic_req,
  output logic [PC_WIDTH-1:0] ic_addr,
  input  logic                ic_ready,
  input  logic [15:0]         ic_data,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         id_ir,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic                id_valid
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fsm_t;

  fsm_t                fsm, fsm_nxt;
  logic [PC_WIDTH-1:0] pc_nxt, id_pc_nxt, buf_pc, buf_pc_nxt, flush_addr, flush_addr_nxt;
  logic [15:0]         id_ir_nxt, buf_ir, buf_ir_nxt;
  logic                id_valid_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm        <= IDLE;
      pc         <= RESET_PC;
      id_ir      <= NOP_IR;
      id_pc      <= '0;
      id_valid   <= 1'b0;
      buf_ir     <= NOP_IR;
      buf_pc     <= RESET_PC;
      flush_addr <= RESET_PC;
    end else begin
      fsm        <= fsm_nxt;
      pc         <= pc_nxt;
      id_ir      <= id_ir_nxt;
      id_pc      <= id_pc_nxt;
      id_valid   <= id_valid_nxt;
      buf_ir     <= buf_ir_nxt;
      buf_pc     <= buf_pc_nxt;
      flush_addr <= flush_addr_nxt;
    end
  end

  always_comb begin
    fsm_nxt        = fsm;
    pc_nxt         = pc;
    id_ir_nxt      = id_ir;
    id_pc_nxt      = id_pc;
    id_valid_nxt   = id_valid;
    buf_ir_nxt     = buf_ir;
    buf_pc_nxt     = buf_pc;
    flush_addr_nxt = flush_addr;
    ic_req         = 1'b0;
    ic_addr        = pc;

    case (fsm)
      IDLE: begin
        id_ir_nxt    = NOP_IR;
        id_valid_nxt = 1'b0;
        if (state) fsm_nxt = FETCH;
      end

      FETCH: begin
        ic_req = 1'b1;
        if (!state || br_taken) begin
          id_ir_nxt    = NOP_IR;
          id_valid_nxt = 1'b0;
          if (br_taken) pc_nxt = br_addr;
          // An unanswered request must still be drained before leaving.
          if (!ic_ready) begin
            fsm_nxt        = FLUSH;
            flush_addr_nxt = pc;
          end else if (!state) begin
            fsm_nxt = IDLE;
          end
        end else if (ic_ready) begin
          pc_nxt = pc + PC_ONE;
          if (stall) begin
            buf_ir_nxt = ic_data;
            buf_pc_nxt = pc;
            fsm_nxt    = HOLD;
          end else begin
            id_ir_nxt    = ic_data;
            id_pc_nxt    = pc;
            id_valid_nxt = 1'b1;
          end
        end else if (!stall) begin
          id_ir_nxt    = NOP_IR;
          id_valid_nxt = 1'b0;
        end
      end

      HOLD: begin
        if (!state) begin
          // Dropping the buffered word means refetching it on restart.
          pc_nxt       = br_taken ? br_addr : buf_pc;
          id_ir_nxt    = NOP_IR;
          id_valid_nxt = 1'b0;
          fsm_nxt      = IDLE;
        end else if (br_taken) begin
          pc_nxt       = br_addr;
          id_ir_nxt    = NOP_IR;
          id_valid_nxt = 1'b0;
          fsm_nxt      = FETCH;
        end else if (!stall) begin
          id_ir_nxt    = buf_ir;
          id_pc_nxt    = buf_pc;
          id_valid_nxt = 1'b1;
          fsm_nxt      = FETCH;
        end
      end

      FLUSH: begin
        ic_req       = 1'b1;
        ic_addr      = flush_addr;
        id_ir_nxt    = NOP_IR;
        id_valid_nxt = 1'b0;
        if (br_taken) pc_nxt = br_addr;
        if (ic_ready) fsm_nxt = state ? FETCH : IDLE;
      end

      default: fsm_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
